// File: rtl/dsp_fe_lane_align.sv
// Lane deskew, sample reorder to timestep order and frame-rotation slip for the ADC frontend.
// Optional monitor ports (frame count, skew saturation flag) are enabled by DSP_FE_LANE_ALIGN_MON_EN.
module dsp_fe_lane_align #(
    parameter  int LaneWidth = 16,
    parameter  int DesWidth  = 2,
    parameter  int AdcWidth  = 6,
    parameter  int MaxSkew   = 3,
    localparam int SkewW     = $clog2(MaxSkew + 1),
    localparam int N         = LaneWidth * DesWidth,
    localparam int PtrW      = $clog2(N)
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_valid,
    input  logic [LaneWidth*AdcWidth*DesWidth-1:0] i_dat_lad,
    input  logic [LaneWidth*SkewW-1:0]             i_skew_cfg,
    input  logic                                   i_cfg_load,
    input  logic                                   i_slip,
    output logic                                   o_valid,
    output logic [N*AdcWidth-1:0]                  o_dat,
    output logic [PtrW-1:0]                        o_slip_ptr,
    output logic                                   o_locked
`ifdef DSP_FE_LANE_ALIGN_MON_EN
    ,
    output logic [31:0]                            o_frame_cnt,
    output logic                                   o_skew_sat
`endif
);

    localparam int LaneBits  = AdcWidth * DesWidth;
    localparam int FlushW    = $clog2(MaxSkew + 3);
    localparam int FlushInit = MaxSkew + 2;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    logic [LaneBits-1:0]   dl_q [LaneWidth][MaxSkew+1];
    logic [SkewW-1:0]      skew_q [LaneWidth];
    logic [SkewW-1:0]      skew_d [LaneWidth];
    logic                  v1_q, v2_q;
    logic [N*AdcWidth-1:0] cur_q, prev_q, cur_d;
    logic [N*AdcWidth-1:0] dat_q, dat_d;
    logic                  valid_q;
    logic [PtrW-1:0]       ptr_q, ptr_d;
    state_t                state_q, state_d;
    logic [FlushW-1:0]     flush_q, flush_d;
    logic                  cfg_event;

    assign cfg_event = i_cfg_load | i_slip;

    function automatic logic [SkewW-1:0] sat_skew(input logic [SkewW-1:0] v);
        return (int'(v) > MaxSkew) ? SkewW'(MaxSkew) : v;
    endfunction

    // NOTE: the delay line is a register array, not RAM, so it is cleared by reset
    // like every other pipeline stage; this keeps post-reset frames deterministic.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int l = 0; l < LaneWidth; l++)
                for (int j = 0; j <= MaxSkew; j++)
                    dl_q[l][j] <= '0;
        end else if (i_valid) begin
            for (int l = 0; l < LaneWidth; l++) begin
                dl_q[l][0] <= i_dat_lad[l*LaneBits +: LaneBits];
                for (int j = 1; j <= MaxSkew; j++)
                    dl_q[l][j] <= dl_q[l][j-1];
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        cur_d = '0;
        for (int l = 0; l < LaneWidth; l++)
            for (int d = 0; d < DesWidth; d++)
                for (int b = 0; b < AdcWidth; b++)
                    cur_d[(l + d*LaneWidth)*AdcWidth + b] = dl_q[l][skew_q[l]][b*DesWidth + d];
    end

    // Window {cur, prev} indexed from N - r: rotation pulls the tail of the previous frame in front.
    always_comb begin
        dat_d = '0;
        for (int k = 0; k < N; k++) begin
            if (k >= int'(ptr_q))
                dat_d[k*AdcWidth +: AdcWidth] = cur_q[(k - int'(ptr_q))*AdcWidth +: AdcWidth];
            else
                dat_d[k*AdcWidth +: AdcWidth] = prev_q[(N - int'(ptr_q) + k)*AdcWidth +: AdcWidth];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            cur_q   <= '0;
            prev_q  <= '0;
            dat_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            v1_q    <= i_valid;
            v2_q    <= v1_q;
            valid_q <= v2_q && (state_q == ST_RUN);
            if (v1_q) begin
                prev_q <= cur_q;
                cur_q  <= cur_d;
            end
            if (v2_q)
                dat_q <= dat_d;
        end
    end

    always_comb begin
        skew_d = skew_q;
        if (i_cfg_load)
            for (int l = 0; l < LaneWidth; l++)
                skew_d[l] = sat_skew(i_skew_cfg[l*SkewW +: SkewW]);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (i_slip)
            ptr_d = (ptr_q == PtrW'(N - 1)) ? '0 : ptr_q + 1'b1;
    end

    // Any reconfiguration restarts the flush so stale delay-line contents never reach the output.
    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        case (state_q)
            ST_FLUSH: begin
                if (cfg_event)
                    flush_d = FlushW'(FlushInit);
                else if (flush_q == '0)
                    state_d = ST_RUN;
                else if (v1_q)
                    flush_d = flush_q - 1'b1;
            end
            ST_RUN: begin
                if (cfg_event) begin
                    state_d = ST_FLUSH;
                    flush_d = FlushW'(FlushInit);
                end
            end
            default: begin
                state_d = ST_FLUSH;
                flush_d = FlushW'(FlushInit);
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_FLUSH;
            flush_q <= FlushW'(FlushInit);
            ptr_q   <= '0;
            for (int l = 0; l < LaneWidth; l++)
                skew_q[l] <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            ptr_q   <= ptr_d;
            skew_q  <= skew_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_dat      = dat_q;
    assign o_slip_ptr = ptr_q;
    assign o_locked   = (state_q == ST_RUN);

`ifdef DSP_FE_LANE_ALIGN_MON_EN
    logic [31:0] frame_cnt_q;
    logic        skew_sat_q;
    logic        skew_over;

    always_comb begin
        skew_over = 1'b0;
        for (int l = 0; l < LaneWidth; l++)
            if (int'(i_skew_cfg[l*SkewW +: SkewW]) > MaxSkew)
                skew_over = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            frame_cnt_q <= '0;
            skew_sat_q  <= 1'b0;
        end else begin
            if (cfg_event)
                frame_cnt_q <= '0;
            else if (valid_q)
                frame_cnt_q <= frame_cnt_q + 32'd1;
            if (i_cfg_load && skew_over)
                skew_sat_q <= 1'b1;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
    assign o_skew_sat  = skew_sat_q;
`endif

endmodule

// File: tb/tb_dsp_fe_lane_align.sv
// Scoreboard bench for dsp_fe_lane_align: frames tagged with an id, expected outputs derived
// from the id, the modelled skew table and the modelled slip pointer.
module tb_dsp_fe_lane_align;

    localparam int LW = 16;
    localparam int DW = 2;
    localparam int AW = 6;
    localparam int MS = 3;
    localparam int N  = LW * DW;
    localparam int SW = 2;
    localparam int PW = 5;
    localparam int FB = LW * AW * DW;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic [FB-1:0] i_dat_lad;
    logic [LW*SW-1:0] i_skew_cfg;
    logic          i_cfg_load;
    logic          i_slip;
    logic          o_valid;
    logic [N*AW-1:0] o_dat;
    logic [PW-1:0] o_slip_ptr;
    logic          o_locked;
`ifdef DSP_FE_LANE_ALIGN_MON_EN
    logic [31:0]   o_frame_cnt;
    logic          o_skew_sat;
`endif

    dsp_fe_lane_align #(
        .LaneWidth(LW), .DesWidth(DW), .AdcWidth(AW), .MaxSkew(MS)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_dat_lad  (i_dat_lad),
        .i_skew_cfg (i_skew_cfg),
        .i_cfg_load (i_cfg_load),
        .i_slip     (i_slip),
        .o_valid    (o_valid),
        .o_dat      (o_dat),
        .o_slip_ptr (o_slip_ptr),
        .o_locked   (o_locked)
`ifdef DSP_FE_LANE_ALIGN_MON_EN
        ,
        .o_frame_cnt(o_frame_cnt),
        .o_skew_sat (o_skew_sat)
`endif
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [N*AW-1:0] dat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int fid = 0;
    int fmul = 0;
    int discard = MS + 2;
    int r_m = 0;
    int skew_m[LW];
    logic [N*AW-1:0] last_out;
    bit seen = 0;

    function automatic logic [AW-1:0] val(int f, int l, int d);
        return AW'(l + LW*d + fmul*f);
    endfunction

    function automatic logic [FB-1:0] build_frame(int f);
        logic [FB-1:0] fr;
        logic [AW-1:0] v;
        fr = '0;
        for (int l = 0; l < LW; l++)
            for (int d = 0; d < DW; d++) begin
                v = val(f, l, d);
                for (int b = 0; b < AW; b++)
                    fr[l*AW*DW + b*DW + d] = v[b];
            end
        return fr;
    endfunction

    function automatic logic [AW-1:0] cur_exp(int f, int t);
        int l;
        l = t % LW;
        return val(f - skew_m[l], l, t / LW);
    endfunction

    function automatic logic [N*AW-1:0] exp_frame(int f);
        logic [N*AW-1:0] o;
        for (int k = 0; k < N; k++)
            o[k*AW +: AW] = (k >= r_m) ? cur_exp(f, k - r_m) : cur_exp(f - 1, N - r_m + k);
        return o;
    endfunction

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (!o_locked) seen = 0;
            if (o_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid at cycle %0d (no frame expected)", cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc !== cyc) begin
                        errors++;
                        $display("FAIL latency: o_valid at cycle %0d, required cycle %0d", cyc, e.cyc);
                    end
                    checks++;
                    if (o_dat !== e.dat) begin
                        errors++;
                        $display("FAIL data at cycle %0d: got %h required %h", cyc, o_dat, e.dat);
                    end
                end
                last_out = o_dat;
                seen = 1;
            end else if (seen) begin
                checks++;
                if (o_dat !== last_out) begin
                    errors++;
                    $display("FAIL hold at cycle %0d: got %h required %h", cyc, o_dat, last_out);
                end
            end
        end
    endtask

    task automatic drive(int n, int gap);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
            i_valid   = 1'b1;
            i_dat_lad = build_frame(fid);
            if (discard > 0) begin
                discard--;
            end else begin
                e.cyc = cyc + 3;
                e.dat = exp_frame(fid);
                sb.push_back(e);
            end
            fid++;
            repeat (gap) begin
                @(posedge i_clk); #1;
                i_valid = 1'b0;
            end
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic drain(string name);
        int w;
        w = 0;
        while (sb.size() != 0 && w < 40) begin
            @(negedge i_clk);
            w++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d frames outstanding, required 0", name, sb.size());
        end
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_locked !== 1'b1) begin
            errors++;
            $display("FAIL %s_locked: got %b required 1", name, o_locked);
        end
    endtask

    task automatic pulse(bit slip, bit load, logic [LW*SW-1:0] cfg);
        int v;
        @(posedge i_clk); #1;
        i_slip     = slip;
        i_cfg_load = load;
        i_skew_cfg = cfg;
        if (slip) r_m = (r_m + 1) % N;
        if (load)
            for (int l = 0; l < LW; l++) begin
                v = int'(cfg[l*SW +: SW]);
                skew_m[l] = (v > MS) ? MS : v;
            end
        discard = MS + 2;
        @(posedge i_clk); #1;
        i_slip     = 1'b0;
        i_cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checks += 4;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", o_valid); end
        if (o_dat !== '0) begin errors++; $display("FAIL reset_dat: got %h required 0", o_dat); end
        if (o_slip_ptr !== '0) begin errors++; $display("FAIL reset_ptr: got %0d required 0", o_slip_ptr); end
        if (o_locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b required 0", o_locked); end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
    endtask

    task automatic test_passthrough();
        fmul = 0;
        drive(12, 0);
        drain("passthrough");
    endtask

    task automatic test_skew();
        logic [LW*SW-1:0] c;
        fmul = 5;
        c = '0;
        c[5*SW +: SW] = 2'd2;
        pulse(0, 1, c);
        @(negedge i_clk);
        checks++;
        if (o_locked !== 1'b0) begin errors++; $display("FAIL skew_unlock: got %b required 0", o_locked); end
        drive(12, 0);
        drain("skew");
    endtask

    task automatic test_slip();
        for (int i = 0; i < 3; i++) pulse(1, 0, '0);
        @(negedge i_clk);
        checks++;
        if (o_slip_ptr !== PW'(3)) begin errors++; $display("FAIL slip_ptr: got %0d required 3", o_slip_ptr); end
        drive(12, 0);
        drain("slip");
    endtask

    task automatic test_slip_wrap();
        for (int i = 0; i < 29; i++) pulse(1, 0, '0);
        @(negedge i_clk);
        checks++;
        if (o_slip_ptr !== '0) begin errors++; $display("FAIL wrap_ptr: got %0d required 0", o_slip_ptr); end
        drive(10, 0);
        drain("wrap");
    endtask

    task automatic test_slip_and_load();
        logic [LW*SW-1:0] c;
        for (int l = 0; l < LW; l++) c[l*SW +: SW] = SW'(l % (MS + 1));
        pulse(1, 1, c);
        @(negedge i_clk);
        checks++;
        if (o_slip_ptr !== PW'(1)) begin errors++; $display("FAIL combo_ptr: got %0d required 1", o_slip_ptr); end
        drive(10, 0);
        drain("combo");
    endtask

    task automatic test_sparse();
        drive(12, 2);
        drain("sparse");
    endtask

    task automatic test_reset_mid();
        drive(7, 2);
        i_rst = 1'b1;
        sb.delete();
        r_m = 0;
        for (int l = 0; l < LW; l++) skew_m[l] = 0;
        discard = MS + 2;
        @(negedge i_clk);
        checks += 3;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", o_valid); end
        if (o_locked !== 1'b0) begin errors++; $display("FAIL midrst_locked: got %b required 0", o_locked); end
        if (o_slip_ptr !== '0) begin errors++; $display("FAIL midrst_ptr: got %0d required 0", o_slip_ptr); end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        drive(12, 2);
        drain("midrst");
    endtask

`ifdef DSP_FE_LANE_ALIGN_MON_EN
    task automatic test_monitor();
        pulse(1, 0, '0);
        drive(MS + 2 + 100, 0);
        drain("mon");
        checks += 2;
        if (o_frame_cnt !== 32'd100) begin errors++; $display("FAIL mon_count: got %0d required 100", o_frame_cnt); end
        if (o_skew_sat !== 1'b0) begin errors++; $display("FAIL mon_sat: got %b required 0", o_skew_sat); end
        pulse(1, 0, '0);
        @(negedge i_clk);
        checks++;
        if (o_frame_cnt !== '0) begin errors++; $display("FAIL mon_clear: got %0d required 0", o_frame_cnt); end
    endtask
`endif

    initial begin
        i_rst      = 1'b1;
        i_valid    = 1'b0;
        i_dat_lad  = '0;
        i_skew_cfg = '0;
        i_cfg_load = 1'b0;
        i_slip     = 1'b0;
        for (int l = 0; l < LW; l++) skew_m[l] = 0;
        fork
            monitor_loop();
            begin
                #100000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_passthrough();
        test_skew();
        test_slip();
        test_slip_wrap();
        test_slip_and_load();
        test_sparse();
        test_reset_mid();
`ifdef DSP_FE_LANE_ALIGN_MON_EN
        test_monitor();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d frames never produced, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
